// File: rtl/if_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues in-order req/gnt/rvalid
// requests and buffers returned words with their PCs for the IF/ID register.
`ifndef ISA_NOP
`define ISA_NOP 32'h0000_0013
`endif

module if_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic [31:0] fe_pc,
    output logic [31:0] fe_insn,
    output logic        fe_valid,
    output logic        busy
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
    localparam logic [CW:0] DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   insn_mem [FIFO_DEPTH];

    logic        redirect;
    logic [31:0] target;
    logic        credit_ok;
    logic        issue;
    logic        push;
    logic        pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    assign redirect  = flush | br_taken;
    assign target    = (flush ? new_pc : br_addr) & ~32'h3;
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
    assign mem_req   = reset && !redirect && credit_ok;
    assign mem_addr  = fetch_pc;
    assign issue     = mem_req && mem_gnt;
    assign push      = mem_rvalid && !redirect && (drop_cnt == '0);
    assign fe_valid  = (fifo_count != '0);
    assign pop       = fe_valid && !stall && !redirect;
    assign fe_pc     = fe_valid ? pc_mem[rd_ptr] : '0;
    assign fe_insn   = fe_valid ? insn_mem[rd_ptr] : `ISA_NOP;
    assign busy      = (outstanding != '0);

    assign outstanding_next = outstanding + CW'(issue) - CW'(mem_rvalid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= START_PC;
            resp_pc     <= START_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                // Every request still in flight after this edge is stale, including
                // ones already marked for dropping, so the count is taken afresh.
                fetch_pc   <= target;
                resp_pc    <= target;
                drop_cnt   <= outstanding_next;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (mem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    wr_ptr  <= next_ptr(wr_ptr);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) rd_ptr <= next_ptr(rd_ptr);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            insn_mem[wr_ptr] <= mem_rdata;
        end
    end

    // The issue credit covers every FIFO slot, so a push can never meet a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) assert (!(push && ({1'b0, fifo_count} == DEPTH_W)));
    end

endmodule
